// File: rtl/fetch_req_ctrl_if.sv
// rtl/fetch_req_ctrl_if.sv - ICache fetch request/response handshake bundle
// Master drives the request and the stale-response flag; slave is the ICache side.
interface fetch_req_ctrl_if;
  logic        inst_req;
  logic [31:0] req_vaddr_o;
  logic [3:0]  req_enable_o;
  logic        resp_discard_o;
  logic        inst_index_ok;
  logic        inst_data_ok;

  modport master (
    output inst_req,
    output req_vaddr_o,
    output req_enable_o,
    output resp_discard_o,
    input  inst_index_ok,
    input  inst_data_ok
  );

  modport slave (
    input  inst_req,
    input  req_vaddr_o,
    input  req_enable_o,
    input  resp_discard_o,
    output inst_index_ok,
    output inst_data_ok
  );
endinterface

// File: rtl/fetch_req_ctrl.sv
// rtl/fetch_req_ctrl.sv - IF stage-1 fetch PC owner and ICache request sequencer
// Tracks in-flight requests and marks responses stale after a redirect.
module fetch_req_ctrl #(
  parameter logic [31:0] RESET_PC  = 32'hBFC0_0000,
  parameter int          MAX_OUTST = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    exc_redirect_i,
  input  logic [31:0]             exc_pc_i,
  input  logic                    br_redirect_i,
  input  logic [31:0]             br_pc_i,
  input  logic                    pred_take_i,
  input  logic [31:0]             pred_pc_i,
  input  logic                    down_allowin_i,
  fetch_req_ctrl_if.master        icache,
  output logic [1:0]              outst_cnt_o,
  output logic                    busy_o
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_REQ   = 2'd1;
  localparam logic [1:0] ST_HOLD  = 2'd2;
  localparam logic [1:0] ST_FLUSH = 2'd3;
  localparam logic [1:0] MAX_CNT  = 2'(MAX_OUTST);

  logic [1:0]  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [1:0]  outst_q, outst_d;
  logic [1:0]  discard_q, discard_d;

  logic        can_issue;
  logic        req;
  logic        fire;
  logic        resp_ok;
  logic        drop;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        unused_pc_bits;

  always_comb begin
    can_issue   = (outst_q < MAX_CNT) && down_allowin_i;
    req         = (state_q == ST_REQ) && can_issue;
    fire        = req && icache.inst_index_ok;
    // A response with nothing in flight is a protocol error and is ignored.
    resp_ok     = icache.inst_data_ok && (outst_q != 2'd0);
    drop        = icache.inst_data_ok && (discard_q != 2'd0);
    redirect    = exc_redirect_i || br_redirect_i;
    redirect_pc = exc_redirect_i ? exc_pc_i : br_pc_i;

    outst_d = outst_q;
    if (fire && !resp_ok) begin
      outst_d = outst_q + 2'd1;
    end else if (!fire && resp_ok) begin
      outst_d = outst_q - 2'd1;
    end

    // Everything still in flight after this cycle, including a same-cycle fire, is stale.
    discard_d = redirect ? outst_d : (discard_q - {1'b0, drop});

    pc_d = pc_q;
    if (redirect) begin
      pc_d = redirect_pc;
    end else if (fire) begin
      pc_d = pred_take_i ? pred_pc_i : {pc_q[31:4] + 28'd1, 4'b0000};
    end

    state_d = state_q;
    case (state_q)
      ST_IDLE:  state_d = ST_REQ;
      ST_REQ:   if (!can_issue) state_d = ST_HOLD;
      ST_HOLD:  if (can_issue) state_d = ST_REQ;
      ST_FLUSH: state_d = ST_REQ;
      default:  state_d = ST_IDLE;
    endcase
    if (redirect && (state_q != ST_IDLE)) begin
      state_d = ST_FLUSH;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      pc_q      <= RESET_PC;
      outst_q   <= 2'd0;
      discard_q <= 2'd0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      outst_q   <= outst_d;
      discard_q <= discard_d;
    end
  end

  assign icache.inst_req       = req;
  assign icache.req_vaddr_o    = {pc_q[31:2], 2'b00};
  assign icache.req_enable_o   = 4'(4'b1111 << pc_q[3:2]);
  assign icache.resp_discard_o = drop;
  assign outst_cnt_o           = outst_q;
  assign busy_o                = (outst_q != 2'd0) || (state_q != ST_IDLE);
  assign unused_pc_bits        = ^pc_q[1:0];

endmodule
